seq_calc_alu: RTL
=================

Name: seq_calc_alu

Overview:
Parametrised, clocked successor to the 8-bit calculator ALU. It accepts an opcode, two operands and a use-saved-result select over a start/busy/done handshake, and holds the result in an internal accumulator register. Add, subtract and logic ops complete in one cycle. Multiply is an iterative shift-add over N cycles. Out-of-range results raise a registered error flag instead of only printing a message. It sits between the operand/keypad front end and the display driver.

Parameters:
N, 8, operand/result width in bits (N >= 2)
CW, $clog2(N+1), width of multiply iteration counter (derived, not overridable)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted when start=1 and busy=0
ope  input  3  000 clear, 001 add, 010 sub, 011 mul, 100 and, 101 or, 110 not, 111 xor
uas  input  1  1: second operand is saved result res (NOT uses res as its sole operand)
in1  input  N  first operand
in2  input  N  second operand (ignored when uas=1)
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse: res/err updated this cycle
res  output  N  accumulator / last result
err  output  1  out-of-range flag for the last completed op

Behaviour:
- Reset: asynchronous, active-high; when rst=1, res=0, err=0, done=0, busy=0, state=IDLE. Reset during MUL aborts the multiply with no partial result written.
- Operand b = uas ? res : in2; NOT computes ~(uas ? res : in1). Operands are sampled only on the accept edge; later input changes are ignored.
- FSM states: IDLE, MUL.
  - IDLE: on accept with ope != 011, compute, write res and err, assert done next cycle; stay IDLE. Latency 1.
  - IDLE: on accept with ope = 011, latch the multiplicand, the multiplier and a 2N-bit product accumulator (=0), set cnt=0 and busy=1, go to MUL.
  - MUL: one multiplier bit per edge. After the N-th step, res = product[N-1:0], err = |product[2N-1:N], done=1, busy=0, go to IDLE. Latency N+1 from accept to done visible.
- start while busy=1 is ignored; it is not queued.
- Arithmetic is width N and unsigned, and truncates on overflow:
  - add: err = carry out of bit N-1.
  - sub: err = (a < b); res = a-b mod 2^N.
  - mul: err as above.
- Logic ops and clear always set err=0. Clear sets res=0 and pulses done.
- err is not sticky: it is rewritten on every completed op.
- Without an accepted start, res holds its value indefinitely.
- done is high for exactly one cycle per accepted op, never without a preceding accept.

Optional Feature:
SEQ_CALC_SAT_EN
- Defined: saturating arithmetic.
  - add/mul overflow gives res = all ones.
  - sub underflow gives res = 0.
  - err still set as above.
- Undefined: wrap-around truncation as specified in Behaviour.
- Logic ops and latency are identical in both builds.

Decomposition:
- Package calc_pkg:
  - opcode constants OP_CLR..OP_XOR (3-bit)
  - state encoding ST_IDLE/ST_MUL
  - default width constant CALC_W=8
- One natural sub-module: seq_shift_mult (parameter N; start, operands in, busy, done, 2N-bit product out). It owns the counter and accumulator. The top FSM owns res, err, the handshake, the single-cycle datapath and the SAT_EN clamp.

Test Plan:
- Reset mid-multiply: start mul 15*15 with N=8, assert rst after 3 cycles -> res=0, busy=0, done never pulses; next add 1+2 -> res=3 after 1 cycle.
- Add overflow, N=8: 200+100, uas=0 -> res=44 (0x2C), err=1, done pulse 1 cycle after accept; with SEQ_CALC_SAT_EN -> res=255, err=1.
- Sub with saved result: res=10, then ope=010, in1=3, uas=1 -> res=249 (0xF9), err=1; then in1=250, uas=1 -> res=1, err=0.
- Multiply timing, N=8: 12*11 -> busy high 8 cycles, done 9 cycles after accept, res=132, err=0; 16*16 -> res=0, err=1 (255 with SAT_EN).
- Start while busy: pulse add during an in-progress mul -> ignored; exactly one done (for the mul); res = product.
- Logic/NOT/clear: 0xF0 xor 0x3C -> 0xCC; NOT with uas=1 -> 0x33; clear -> res=0, err=0. Repeat the multiply case at N=16: 300*200 -> res=60000, err=0, done 17 cycles after accept.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator ALU.
//   CALC_W          default operand/result width
//   OP_CLR..OP_XOR  3-bit opcodes presented on the ope input
//   state_t         controller state encoding (ST_IDLE, ST_MUL)
package calc_pkg;

  localparam int CALC_W = 8;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_shift_mult.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (aborts a run)
//   start           load operands and begin; ignored while busy
//   a, b            multiplicand, multiplier (N bits)
//   busy            high while steps remain
//   done            high during the final step's cycle
//   product         2N-bit accumulator value after the current step
// product is the combinational next accumulator so the caller can capture
// the finished result on the same edge as the N-th step.
module seq_shift_mult
  import calc_pkg::*;
#(
  parameter int N = CALC_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]  cnt;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [N-1:0]   mplr;
  logic           run;
  logic           last;

  assign last     = run && (cnt == CW'(N - 1));
  assign acc_next = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (start && !run) begin
      run   <= 1'b1;
      cnt   <= '0;
      mcand <= {{N{1'b0}}, a};
      mplr  <= b;
      acc   <= '0;
    end else if (run) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CW'(1);
      if (last) run <= 1'b0;
    end
  end

  assign busy    = run;
  assign done    = last;
  assign product = acc_next;

endmodule

// File: rtl/seq_calc_alu.sv
// Clocked calculator ALU with accumulator register and start/busy/done
// handshake. Add/sub/logic/clear complete in one cycle; multiply runs
// N steps in seq_shift_mult.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request, accepted when idle
//   ope        opcode (see calc_pkg)
//   uas        use saved result res as second operand (NOT: sole operand)
//   in1, in2   operands (N bits)
//   busy       multiply in progress
//   done       one-cycle pulse when res/err were written
//   res        accumulator / last result
//   err        out-of-range flag of the last completed op
// Build option: define SEQ_CALC_SAT_EN to clamp add/mul overflow to all
// ones and sub underflow to zero instead of wrapping.
//
// state   | meaning
// ST_IDLE | waiting for start; single-cycle ops complete here
// ST_MUL  | multiplier stepping, further starts ignored
module seq_calc_alu
  import calc_pkg::*;
#(
  parameter int N = CALC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   ope,
  input  logic         uas,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic         err
);

  state_t         state;
  logic [N-1:0]   op_b;
  logic [N:0]     sum;
  logic [N-1:0]   diff;
  logic           borrow;
  logic [N-1:0]   alu_res;
  logic           alu_err;
  logic           m_start;
  logic           m_busy;
  logic           m_done;
  logic [2*N-1:0] m_prod;
  logic           m_ovf;
  logic [N-1:0]   mul_res;

  assign op_b   = uas ? res : in2;
  assign sum    = {1'b0, in1} + {1'b0, op_b};
  assign diff   = in1 - op_b;
  assign borrow = in1 < op_b;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (ope)
      OP_ADD: begin
        alu_err = sum[N];
`ifdef SEQ_CALC_SAT_EN
        alu_res = sum[N] ? '1 : sum[N-1:0];
`else
        alu_res = sum[N-1:0];
`endif
      end
      OP_SUB: begin
        alu_err = borrow;
`ifdef SEQ_CALC_SAT_EN
        alu_res = borrow ? '0 : diff;
`else
        alu_res = diff;
`endif
      end
      OP_AND:  alu_res = in1 & op_b;
      OP_OR:   alu_res = in1 | op_b;
      OP_NOT:  alu_res = ~(uas ? res : in1);
      OP_XOR:  alu_res = in1 ^ op_b;
      default: alu_res = '0;
    endcase
  end

  // Multiplier is only kicked from idle, so a start during busy is dropped.
  assign m_start = start && (state == ST_IDLE) && !m_busy && (ope == OP_MUL);
  assign m_ovf   = |m_prod[2*N-1:N];
`ifdef SEQ_CALC_SAT_EN
  assign mul_res = m_ovf ? '1 : m_prod[N-1:0];
`else
  assign mul_res = m_prod[N-1:0];
`endif

  seq_shift_mult #(.N(N)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (m_start),
    .a       (in1),
    .b       (op_b),
    .busy    (m_busy),
    .done    (m_done),
    .product (m_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      res   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (ope == OP_MUL) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else begin
              res  <= alu_res;
              err  <= alu_err;
              done <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (m_done) begin
            res   <= mul_res;
            err   <= m_ovf;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
